// File: rtl/lcv_mul_acc_pkg.sv
// Shared types and widths for the round-robin shared multiply-accumulate block.
package lcv_mul_acc_pkg;

  localparam int MAC_OPND_W   = 16;
  localparam int MAC_SUM_W    = 33;
  localparam int RSP_ID_MAX_W = 8;

  typedef struct packed {
    logic [MAC_OPND_W-1:0] a;
    logic [MAC_OPND_W-1:0] b;
    logic [MAC_SUM_W-1:0]  c;
    logic [MAC_SUM_W-1:0]  d;
    logic [MAC_SUM_W-1:0]  e;
  } mac_op_t;

  // Id field sized for the largest supported requester count; users take the low bits.
  typedef struct packed {
    logic [RSP_ID_MAX_W-1:0] id;
    logic [MAC_SUM_W-1:0]    data;
  } mac_rsp_t;

endpackage

// File: rtl/lcv_mul_acc_mac.sv
// Registered signed MAC datapath: r_outp = a*b + c + d + e, wrapped to 33 bits, one cycle delay.
module lcv_mul_acc_mac
  import lcv_mul_acc_pkg::*;
(
  input  logic                 i_clk,
  input  mac_op_t              i_op,
  output logic [MAC_SUM_W-1:0] o_outp
);

  logic signed [2*MAC_OPND_W-1:0] w_prod;
  logic [MAC_SUM_W-1:0]           r_outp;

  assign w_prod = $signed(i_op.a) * $signed(i_op.b);

  // Datapath register carries no reset; the wrapper masks it with its own valid.
  always_ff @(posedge i_clk) begin
    r_outp <= {w_prod[2*MAC_OPND_W-1], w_prod} + i_op.c + i_op.d + i_op.e;
  end

  assign o_outp = r_outp;

endmodule

// File: rtl/lcv_rr_arb.sv
// Round-robin arbiter: searches the request vector from i_ptr upward, wrapping,
// and returns a one-hot grant plus the winner index.
module lcv_rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any
);

  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = f_wrap(i_ptr, k);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_winner       = w_idx;
      end
    end
  end

endmodule

// File: rtl/lcv_mul_acc_arb.sv
// Round-robin front end sharing one MAC between NUM_REQ requesters, latency 2, in order.
// Optional result chaining (per-requester accumulator as c) under LCV_MUL_ACC_ARB_CHAIN_EN.
module lcv_mul_acc_arb
  import lcv_mul_acc_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*MAC_OPND_W-1:0]  i_req_a,
  input  logic [NUM_REQ*MAC_OPND_W-1:0]  i_req_b,
  input  logic [NUM_REQ*MAC_SUM_W-1:0]   i_req_c,
  input  logic [NUM_REQ*MAC_SUM_W-1:0]   i_req_d,
  input  logic [NUM_REQ*MAC_SUM_W-1:0]   i_req_e,
  input  logic [NUM_REQ-1:0]             i_req_chain,
  output logic                           o_rsp_valid,
  output logic [ID_W-1:0]                o_rsp_id,
  output logic [MAC_SUM_W-1:0]           o_rsp_data
);

  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_next_ptr;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_any;
  logic                 w_accept;
  mac_op_t              w_op;
  mac_op_t              w_mac_in;
  mac_op_t              r_iss_op;
  logic                 r_iss_valid;
  logic [ID_W-1:0]      r_iss_id;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [MAC_SUM_W-1:0] w_mac_out;

`ifdef LCV_MUL_ACC_ARB_CHAIN_EN
  logic [NUM_REQ-1:0]   r_inflight;
  logic                 r_iss_chain;
  logic [MAC_SUM_W-1:0] r_acc [NUM_REQ];

  // A chaining requester must wait for its previous result to land in r_acc.
  assign w_elig = i_req_valid & ~(i_req_chain & r_inflight);
`else
  logic w_unused_chain;
  assign w_unused_chain = ^i_req_chain;
  assign w_elig         = i_req_valid;
`endif

  lcv_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req    (w_elig),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_win),
    .o_any    (w_any)
  );

  assign o_req_ready = i_rst ? '0 : w_grant;
  assign w_accept    = w_any & ~i_rst;
  assign w_next_ptr  = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_op.a = i_req_a[MAC_OPND_W*w_win +: MAC_OPND_W];
    w_op.b = i_req_b[MAC_OPND_W*w_win +: MAC_OPND_W];
    w_op.c = i_req_c[MAC_SUM_W*w_win +: MAC_SUM_W];
    w_op.d = i_req_d[MAC_SUM_W*w_win +: MAC_SUM_W];
    w_op.e = i_req_e[MAC_SUM_W*w_win +: MAC_SUM_W];
  end

  always_comb begin
    w_mac_in = r_iss_op;
`ifdef LCV_MUL_ACC_ARB_CHAIN_EN
    if (r_iss_chain) w_mac_in.c = r_acc[r_iss_id];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_iss_valid <= 1'b0;
      r_iss_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_iss_valid <= w_accept;
      r_rsp_valid <= r_iss_valid;
      r_rsp_id    <= r_iss_id;
      if (w_accept) begin
        r_iss_id <= w_win;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) r_iss_op <= w_op;
  end

`ifdef LCV_MUL_ACC_ARB_CHAIN_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight  <= '0;
      r_iss_chain <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r_acc[i] <= '0;
    end else begin
      if (w_accept) r_iss_chain <= i_req_chain[w_win];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_rsp_valid && r_rsp_id == ID_W'(i)) r_acc[i] <= w_mac_out;
        // A new accept for the same requester overrides the completing op's clear.
        if (w_accept && w_grant[i])
          r_inflight[i] <= 1'b1;
        else if (r_rsp_valid && r_rsp_id == ID_W'(i))
          r_inflight[i] <= 1'b0;
      end
    end
  end
`endif

  lcv_mul_acc_mac u_mac (
    .i_clk  (i_clk),
    .i_op   (w_mac_in),
    .o_outp (w_mac_out)
  );

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_valid ? w_mac_out : '0;

endmodule

// File: tb/tb_lcv_mul_acc_arb.sv
// Bench for lcv_mul_acc_arb: table vectors, scoreboard with arbitration model, corner sequences.
module tb_lcv_mul_acc_arb;

  localparam int N = 4;
`ifdef LCV_MUL_ACC_ARB_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_chain;
  logic [N*16-1:0] req_a, req_b;
  logic [N*33-1:0] req_c, req_d, req_e;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [32:0]     rsp_data;

  logic signed [15:0] ta [N];
  logic signed [15:0] tbv[N];
  logic [32:0]        tc [N];
  logic [32:0]        td [N];
  logic [32:0]        te [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[16*g +: 16] = ta[g];
    assign req_b[16*g +: 16] = tbv[g];
    assign req_c[33*g +: 33] = tc[g];
    assign req_d[33*g +: 33] = td[g];
    assign req_e[33*g +: 33] = te[g];
  end

  lcv_mul_acc_arb #(.NUM_REQ(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_c     (req_c),
    .i_req_d     (req_d),
    .i_req_e     (req_e),
    .i_req_chain (req_chain),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: required event not seen (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [32:0] f_mac(input logic signed [15:0] a, b,
                                        input logic [32:0] c, d, e);
    longint r;
    r = longint'(a) * longint'(b) + longint'($signed(c)) + longint'($signed(d))
      + longint'($signed(e));
    return r[32:0];
  endfunction

  // Scoreboard and reference arbitration model
  typedef struct { int id; logic [32:0] data; int cyc; } exp_t;
  exp_t        q[$];
  exp_t        me;
  int          m_ptr;
  int          m_until[N];
  logic [32:0] m_acc[N];
  logic [N-1:0] mg;
  bit          mfound;
  int          mw, midx;
  logic [32:0] mc;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin
        m_until[i] = -1;
        m_acc[i]   = '0;
      end
      chk("ready_in_rst", 64'(req_ready), 64'd0);
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) fail("rsp_unexpected");
        else begin
          me = q.pop_front();
          chk("sb_id", 64'(rsp_id), 64'(me.id));
          chk("sb_data", 64'(rsp_data), 64'(me.data));
          chk("sb_latency", 64'(cyc - me.cyc), 64'd2);
        end
      end else begin
        chk("rsp_data_idle", 64'(rsp_data), 64'd0);
        if (q.size() > 0 && cyc >= q[0].cyc + 2) begin
          fail("rsp_missing");
          void'(q.pop_front());
        end
      end
      mg = '0; mfound = 1'b0; mw = 0;
      for (int k = 0; k < N; k++) begin
        midx = (m_ptr + k) % N;
        if (!mfound && req_valid[midx] &&
            !(CHAIN && req_chain[midx] && cyc <= m_until[midx])) begin
          mfound = 1'b1; mw = midx; mg[midx] = 1'b1;
        end
      end
      chk("grant", 64'(req_ready), 64'(mg));
      if (mfound) begin
        mc = (CHAIN && req_chain[mw]) ? m_acc[mw] : tc[mw];
        me.id = mw;
        me.data = f_mac(ta[mw], tbv[mw], mc, td[mw], te[mw]);
        me.cyc = cyc;
        q.push_back(me);
        m_acc[mw]   = me.data;
        m_until[mw] = cyc + 2;
        m_ptr       = (mw + 1) % N;
      end
    end
  end

  task automatic set_op(input int id, input logic signed [15:0] a, b,
                        input logic [32:0] c, d, e, input logic chain);
    ta[id] = a; tbv[id] = b; tc[id] = c; td[id] = d; te[id] = e;
    req_chain[id] = chain;
  endtask

  task automatic do_op(input int id, input logic signed [15:0] a, b,
                       input logic [32:0] c, d, e, input logic chain);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_op(id, a, b, c, d, e, chain);
    req_valid[id] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1'b1; break; end
    end
    if (!got) fail("accept_timeout");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  typedef struct {
    int id;
    logic signed [15:0] a, b;
    logic [32:0] c, d, e;
    logic [32:0] exp;
  } vec_t;
  vec_t tbl[6];

  logic [32:0] exp5[3];
  int n1, k1, last1;

  initial begin
    tbl[0] = '{0, 16'sd3, -16'sd4, 33'd10, 33'd1, 33'd2, 33'd1};
    tbl[1] = '{1, 16'sd100, 16'sd200, 33'd0, 33'd0, 33'd0, 33'd20000};
    tbl[2] = '{2, -16'sd32768, -16'sd32768, 33'h0FFFFFFFF, 33'h0FFFFFFFF, 33'h0FFFFFFFF,
               33'h13FFFFFFD};
    tbl[3] = '{3, 16'sd32767, -16'sd32768, 33'h1FFFFFFFF, 33'h1FFFFFFFF, 33'h1FFFFFFFF,
               33'd0 - 33'd1073709059};
    tbl[4] = '{0, 16'sd0, 16'sd0, 33'h100000000, 33'h100000000, 33'd5, 33'd5};
    tbl[5] = '{1, -16'sd1, -16'sd1, 33'h0FFFFFFFF, 33'd0, 33'd0, 33'h100000000};
    if (CHAIN) exp5 = '{33'd6, 33'd7, 33'd8};
    else       exp5 = '{33'd1000, 33'd1000, 33'd1000};

    rst = 1'b1;
    req_chain = '0;
    for (int i = 0; i < N; i++)
      set_op(i, 16'(i + 1), -16'(i + 2), 33'(10 * i), 33'd3, 33'd0, 1'b0);
    req_valid = '1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);

    // All four requesters valid from reset: strict 0,1,2,3 rotation
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_rotation", 64'(req_ready), 64'(4'b0001 << (k % 4)));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Table vectors, one lone requester at a time
    for (int k = 0; k < 6; k++) begin
      do_op(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].d, tbl[k].e, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("tbl_valid", 64'(rsp_valid), 64'd1);
      chk("tbl_id", 64'(rsp_id), 64'(tbl[k].id));
      chk("tbl_data", 64'(rsp_data), 64'(tbl[k].exp));
    end

    // Reset one cycle after acceptance discards the op and clears the pointer
    @(posedge clk); #1;
    set_op(0, 16'sd7, 16'sd7, 33'd1, 33'd1, 33'd1, 1'b0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("rst_flight_accept", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_flight_valid", 64'(rsp_valid), 64'd0);
      chk("rst_flight_data", 64'(rsp_data), 64'd0);
      chk("rst_flight_id", 64'(rsp_id), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("rst_ptr_zero", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Chained requester 1 competing with requester 2
    do_op(1, 16'sd0, 16'sd0, 33'd5, 33'd0, 33'd0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    set_op(1, 16'sd1, 16'sd1, 33'd999, 33'd0, 33'd0, 1'b1);
    set_op(2, 16'sd2, 16'sd3, 33'd0, 33'd0, 33'd1, 1'b0);
    req_valid = 4'b0110;
    n1 = 0; k1 = 0; last1 = 0;
    for (int t = 0; t < 40 && k1 < 3; t++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) begin
        if (n1 > 0) chk("chain_gap", 64'(cyc - last1), CHAIN ? 64'd3 : 64'd2);
        last1 = cyc;
        n1++;
      end
      if (rsp_valid && rsp_id == 2'd1) begin
        chk("chain_data", 64'(rsp_data), 64'(exp5[k1]));
        k1++;
      end
      @(posedge clk); #1;
      if (n1 >= 3) req_valid[1] = 1'b0;
    end
    if (k1 < 3) fail("chain_timeout");
    req_valid = '0;
    req_chain = '0;
    repeat (4) @(negedge clk);

    // Idle cycles leave the pointer where the last grant put it
    do_op(2, 16'sd4, 16'sd5, 33'd0, 33'd0, 33'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_valid", 64'(rsp_valid), 64'd0);
      chk("idle_data", 64'(rsp_data), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("idle_ptr_kept", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
